// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular byte FIFO.
// Bytes enter through a valid/ready handshake and leave LSB first on tx,
// one frame every 10*T clocks with no idle gap while the FIFO has data.
module uart_tx_fifo #(
  parameter int BAUDRATE = 115200,
  parameter int FREQ     = 50_000_000,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [7:0]             wdata,
  input  logic                   wvld,
  output logic                   wrdy,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int T  = FREQ / BAUDRATE;  // clocks per bit
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(T);

  localparam logic [TW-1:0] T_LAST   = TW'(T - 1);
  localparam logic [TW-1:0] CLK_ONE  = TW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   cnt_clk, cnt_clk_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_next, busy_next;
  logic            bit_end;
  logic            pop;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt_next;
  logic [7:0]      mem [DEPTH];

  assign wr_en   = wvld && wrdy;
  assign bit_end = (cnt_clk == T_LAST);

  // FIFO storage write port.
  // NOTE: the data array has no reset; occupancy and pointers alone decide
  // what is valid, so resetting it would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Occupancy after this cycle's write and pop; both together cancel out.
  always_comb begin
    cnt_next = cnt;
    if (wr_en && !pop)      cnt_next = cnt + CNT_ONE;
    else if (!wr_en && pop) cnt_next = cnt - CNT_ONE;
  end

  // FIFO pointers, occupancy and the registered ready flag.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      wrdy   <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      cnt  <= cnt_next;
      wrdy <= (cnt_next != CNT_FULL);
    end
  end

  // Frame sequencer state plus the glitch-free tx and busy registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt_clk   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt_clk   <= cnt_clk_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
      busy      <= busy_next;
    end
  end

  // Next-state logic: bit timing, shifting, and popping the FIFO head.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_clk_next = cnt_clk;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    pop          = 1'b0;

    if (state != IDLE) cnt_clk_next = bit_end ? '0 : cnt_clk + CLK_ONE;

    case (state)
      IDLE: begin
        if (cnt != '0) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          cnt_clk_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_next   = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cnt != '0) begin
            // Back-to-back frame: load the next byte with no idle gap.
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level and busy derived from the current state, registered next edge.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state != IDLE) || (cnt != '0);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus for uart_tx_fifo, checked
// against a byte-queue reference and a line monitor that decodes 8N1 frames.
module tb_uart_tx_fifo;

  localparam int TA    = 434;  // default 50 MHz / 115200
  localparam int TB    = 10;   // FREQ=1000, BAUDRATE=100
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] wdata_a, wdata_b;
  logic       wvld_a, wvld_b;
  logic       wrdy_a, wrdy_b, tx_a, tx_b, busy_a, busy_b;
  logic [3:0] cnt_a, cnt_b;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];
  int         fall_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo u_dut_a (
    .clk(clk), .nrst(nrst), .wdata(wdata_a), .wvld(wvld_a), .wrdy(wrdy_a),
    .tx(tx_a), .busy(busy_a), .cnt(cnt_a)
  );

  uart_tx_fifo #(.BAUDRATE(100), .FREQ(1000), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .nrst(nrst), .wdata(wdata_b), .wvld(wvld_b), .wrdy(wrdy_b),
    .tx(tx_b), .busy(busy_b), .cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of bit slot idx of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx >= 9) return 1'b1;
    else               return b[idx-1];
  endfunction

  // Offer byte b on instance B, holding wvld high until it is accepted.
  // While the FIFO is full, wdata carries garbage that must be ignored.
  task automatic push_b(input logic [7:0] b, output int acc);
    int budget;
    budget = 0;
    wvld_b = 1'b1;
    while (wrdy_b !== 1'b1 && budget < 40 * TB) begin
      wdata_b = 8'($urandom);
      @(negedge clk);
      budget++;
    end
    check("wrdy_wait_bounded", 32'(budget < 40 * TB), 32'd1);
    wdata_b = b;
    acc = cyc + 1;
    exp_q.push_back(b);
    @(negedge clk);
    wvld_b  = 1'b0;
    wdata_b = 8'($urandom);
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 0;
    while (frames_done < n && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check("frames_done", 32'(frames_done), 32'(n));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Line monitor on instance B: decodes each frame, checks every clock of
  // it against the next expected byte and records the start-bit cycle.
  initial begin
    int         k;
    int         bad;
    logic [7:0] e;
    logic [7:0] rx;
    bit         active;
    active = 1'b0;
    k = 0; bad = 0; e = '0; rx = '0;
    forever begin
      @(negedge clk);
      if (nrst !== 1'b1) begin
        active = 1'b0;
      end else begin
        if (!active && tx_b === 1'b0) begin
          active = 1'b1;
          k = 0; bad = 0; rx = '0;
          fall_q.push_back(cyc);
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        end
        if (active) begin
          if (tx_b !== frame_bit(e, k / TB)) bad++;
          if ((k % TB) == TB / 2 && k / TB >= 1 && k / TB <= 8) rx[k / TB - 1] = tx_b;
          k++;
          if (k == 10 * TB) begin
            check("frame_waveform_bad_clocks", 32'(bad), 32'd0);
            check("rx_byte", 32'(rx), 32'(e));
            frames_done++;
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence.
  initial begin
    int acc, a0, a1, a2, d0, first_full, low, gap;
    int bad_a[12];
    logic exp_tx;
    int slot;

    nrst = 1'b0;
    wvld_a = 1'b0; wdata_a = '0;
    wvld_b = 1'b0; wdata_b = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_tx_b",   32'(tx_b),   32'd1);
    check("rst_wrdy_b", 32'(wrdy_b), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_cnt_b",  32'(cnt_b),  32'd0);
    check("rst_tx_a",   32'(tx_a),   32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 at the default rate: exact waveform, 2-clk latency, busy window.
    foreach (bad_a[i]) bad_a[i] = 0;
    check("a_wrdy_before_write", 32'(wrdy_a), 32'd1);
    wdata_a = 8'h55; wvld_a = 1'b1; acc = cyc + 1;
    @(negedge clk);
    wvld_a = 1'b0; wdata_a = 8'hFF;
    for (int k = 0; k <= 10 * TA + 3; k++) begin
      if (k < 2)                begin exp_tx = 1'b1; slot = 10; end
      else if (k < 2 + 10 * TA) begin exp_tx = frame_bit(8'h55, (k - 2) / TA); slot = (k - 2) / TA; end
      else                      begin exp_tx = 1'b1; slot = 11; end
      if (tx_a !== exp_tx) bad_a[slot]++;
      if (k == 0) check("a_cnt_after_accept", 32'(cnt_a), 32'd1);
      if (k == 1) check("a_cnt_after_pop",    32'(cnt_a), 32'd0);
      if (k == 1) check("a_tx_high_at_1clk",  32'(tx_a),  32'd1);
      if (k == 2) check("a_tx_falls_at_2clk", 32'(tx_a),  32'd0);
      if (k == 1 + 10 * TA) check("a_busy_last_clk", 32'(busy_a), 32'd1);
      if (k == 2 + 10 * TA) check("a_busy_dropped",  32'(busy_a), 32'd0);
      @(negedge clk);
    end
    for (int s = 0; s < 12; s++) check($sformatf("a_slot%0d_bad_clocks", s), 32'(bad_a[s]), 32'd0);

    // T=10: 0x3C frame is exactly 100 clk from the start-bit fall.
    fall_q.delete(); d0 = frames_done;
    push_b(8'h3C, acc);
    wait_cyc(acc + 101);
    check("t6_tx_last_stop_clk",   32'(tx_b),   32'd1);
    check("t6_busy_last_stop_clk", 32'(busy_b), 32'd1);
    wait_cyc(acc + 102);
    check("t6_busy_after_frame",   32'(busy_b), 32'd0);
    wait_frames(d0 + 1);
    check("t6_start_latency", 32'(fall_q[0]), 32'(acc + 2));

    // Burst of three: contiguous frames.
    repeat (5) @(negedge clk);
    fall_q.delete(); d0 = frames_done;
    push_b(8'h00, a0);
    push_b(8'hFF, a1);
    push_b(8'hA5, a2);
    check("t2_cnt_after_burst", 32'(cnt_b), 32'd2);
    wait_frames(d0 + 3);
    check("t2_first_fall", 32'(fall_q[0]), 32'(a0 + 2));
    check("t2_gap_1", 32'(fall_q[1] - fall_q[0]), 32'(10 * TB));
    check("t2_gap_2", 32'(fall_q[2] - fall_q[1]), 32'(10 * TB));

    // Write and pop together at the STOP-end boundary with one byte queued.
    repeat (5) @(negedge clk);
    fall_q.delete(); d0 = frames_done;
    push_b(8'h11, a0);
    push_b(8'h22, a1);
    check("t4_cnt_write_with_first_pop", 32'(cnt_b), 32'd1);
    wait_cyc(a0 + 10 * TB);
    check("t4_cnt_before_boundary", 32'(cnt_b), 32'd1);
    push_b(8'h33, a2);
    check("t4_accept_on_boundary", 32'(a2), 32'(a0 + 10 * TB + 1));
    check("t4_cnt_after_boundary", 32'(cnt_b), 32'd1);
    wait_frames(d0 + 3);
    check("t4_fall_1", 32'(fall_q[1]), 32'(a0 + 2 + 10 * TB));
    check("t4_fall_2", 32'(fall_q[2]), 32'(a0 + 2 + 20 * TB));

    // Hold wvld with 0..11: nine accepted before full, nothing lost.
    repeat (5) @(negedge clk);
    fall_q.delete(); d0 = frames_done; first_full = -1;
    for (int i = 0; i < 12; i++) begin
      push_b(8'(i), acc);
      if (first_full < 0 && wrdy_b === 1'b0) begin
        first_full = i + 1;
        check("t3_cnt_when_full", 32'(cnt_b), 32'(DEPTH));
      end
    end
    check("t3_accepted_before_full", 32'(first_full), 32'd9);
    wait_frames(d0 + 12);
    low = 0;
    for (int i = 1; i < 12; i++) if (fall_q[i] - fall_q[i-1] != 10 * TB) low++;
    check("t3_non_contiguous_frames", 32'(low), 32'd0);

    // Random bytes with random idle gaps.
    d0 = frames_done;
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 3 * TB));
      repeat (gap) @(negedge clk);
      push_b(8'($urandom), acc);
    end
    wait_frames(d0 + 8);
    repeat (3) @(negedge clk);
    check("rand_busy_idle", 32'(busy_b), 32'd0);
    check("rand_cnt_empty", 32'(cnt_b),  32'd0);

    // Reset in the middle of the second of three frames.
    fall_q.delete(); d0 = frames_done;
    push_b(8'hC3, a0);
    push_b(8'h5A, a1);
    push_b(8'h0F, a2);
    wait_cyc(a0 + 2 + 14 * TB + 3);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("t5_tx_forced_high", 32'(tx_b),   32'd1);
    check("t5_cnt_cleared",    32'(cnt_b),  32'd0);
    check("t5_wrdy_set",       32'(wrdy_b), 32'd1);
    check("t5_busy_cleared",   32'(busy_b), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    low = 0;
    repeat (40 * TB) begin
      @(negedge clk);
      if (tx_b !== 1'b1) low++;
    end
    check("t5_no_frames_after_reset", 32'(low), 32'd0);
    check("t5_frames_unchanged", 32'(frames_done), 32'(d0 + 1));
    check("t5_cnt_still_zero", 32'(cnt_b), 32'd0);
    check("end_expectations_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
